result_packer: RTL and testbench

- Downstream stage of the MAC/activation datapath.
- Captures each 16-bit result as the MAC array's done strobe qualifies it.
- Packs four results into one 64-bit word and buffers the words in a small show-ahead FIFO.
- Presents the words on a valid/ready stream toward the DMA write-back channel. Flush closes a partial word at end of layer; the upstream side has no backpressure, so full/overflow are reported instead.

---
 rtl/result_packer_if.sv | 26 ++
 rtl/result_packer.sv | 130 +++++++++++++
 tb/tb_result_packer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/result_packer_if.sv
// rtl/result_packer_if.sv - result sample input and packed-word output stream bundle
//
// Purpose: groups the packer's sample input (in_valid/in_data/flush) and its
// packed 64-bit output stream (out_valid/out_ready/out_data/out_keep/out_last).
//   master : the environment side (drives samples and out_ready)
//   slave  : the result_packer side (consumes samples, drives the word stream)
interface result_packer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/result_packer.sv
// rtl/result_packer.sv - packs 16-bit results four to a 64-bit word into a show-ahead FIFO
//
// Purpose: captures each qualified 16-bit result, packs four results per 64-bit
// word (lane 0 = first sample), closes partial words on flush (tagged last) and
// buffers words in a DEPTH-entry show-ahead FIFO feeding a valid/ready stream.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of packer, FIFO and overflow flag
//   bus         : result_packer_if.slave (sample input + packed word stream)
//   full        : FIFO occupancy == DEPTH
//   overflow    : sticky, a completed word was dropped because the FIFO was full
//   word_count  : FIFO occupancy 0..DEPTH
module result_packer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    result_packer_if.slave             bus,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Packer state
    logic [1:0]    r_idx;
    logic [63:0]   r_pack;
    logic [3:0]    r_keep;

    // FIFO state
    logic [68:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic [63:0]   w_word_data;
    logic [3:0]    w_word_keep;
    logic          w_complete;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [68:0]   w_head;

    // Pack register with the incoming sample merged in, so a completing sample
    // reaches the FIFO on the same edge it is captured.
    always_comb begin
        w_word_data = r_pack;
        w_word_keep = r_keep;
        if (bus.in_valid) begin
            w_word_data[{r_idx, 4'b0000} +: 16] = bus.in_data;
            w_word_keep[r_idx]                  = 1'b1;
        end
    end

    // Flush at idx==0 only closes a word if a sample arrives in the same cycle.
    assign w_complete = (bus.in_valid && (r_idx == 2'd3)) ||
                        (bus.flush && (bus.in_valid || (r_idx != 2'd0)));

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = !clr && (r_count != '0) && bus.out_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push = !clr && w_complete && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pack <= '0;
            r_keep <= '0;
        end else if (clr || w_complete) begin
            // A dropped word still restarts the packer at lane 0.
            r_idx  <= '0;
            r_pack <= '0;
            r_keep <= '0;
        end else if (bus.in_valid) begin
            r_idx  <= r_idx + 2'd1;
            r_pack <= w_word_data;
            r_keep <= w_word_keep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_complete && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.flush, w_word_keep, w_word_data};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = bus.out_valid ? w_head[63:0]  : 64'd0;
    assign bus.out_keep  = bus.out_valid ? w_head[67:64] : 4'd0;
    assign bus.out_last  = bus.out_valid ? w_head[68]    : 1'b0;

    assign full       = w_full;
    assign overflow   = r_overflow;
    assign word_count = r_count;
endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - self-checking bench for result_packer against a queue-based model
module tb_result_packer;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          full;
    logic          overflow;
    logic [CW-1:0] word_count;

    result_packer_if bus_if ();

    result_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus_if.slave),
        .full       (full),
        .overflow   (overflow),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t       exp_q[$];
    logic [15:0] pend[$];
    bit          m_ovf;
    int          n_pass;
    int          n_total;
    logic [15:0] seq_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference behaviour: pending samples accumulate in a list; a word forms
    // when four are held or flush arrives with any held; the FIFO is a queue.
    task automatic model_edge(input bit v, input logic [15:0] d, input bit f, input bit r, input bit c);
        word_t w;
        if (c) begin
            pend.delete();
            exp_q.delete();
            m_ovf = 0;
            return;
        end
        if (r && exp_q.size() > 0) w = exp_q.pop_front();
        if (v) pend.push_back(d);
        if (pend.size() == 4 || (f && pend.size() > 0)) begin
            w.d = 64'd0;
            for (int k = 0; k < pend.size(); k++) w.d = w.d | (64'(pend[k]) << (16 * k));
            w.k = 4'((1 << pend.size()) - 1);
            w.l = f;
            pend.delete();
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        check("out_valid", 64'(bus_if.out_valid), 64'(exp_q.size() > 0));
        check("word_count", 64'(word_count), 64'(exp_q.size()));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_q.size() > 0) begin
            check("out_data", bus_if.out_data, exp_q[0].d);
            check("out_keep", 64'(bus_if.out_keep), 64'(exp_q[0].k));
            check("out_last", 64'(bus_if.out_last), 64'(exp_q[0].l));
        end else begin
            check("empty_data", bus_if.out_data, 64'd0);
            check("empty_keep", 64'(bus_if.out_keep), 64'd0);
            check("empty_last", 64'(bus_if.out_last), 64'd0);
        end
    endtask

    // Inputs are applied at the falling edge, the model steps at the rising
    // edge, and outputs are compared at the next falling edge.
    task automatic step(input bit v, input logic [15:0] d, input bit f, input bit r, input bit c);
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.flush     = f;
        bus_if.out_ready = r;
        clr              = c;
        @(posedge clk);
        model_edge(v, d, f, r, c);
        @(negedge clk);
        check_all();
    endtask

    task automatic samples(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            step(1'b1, seq_val, 1'b0, r, 1'b0);
            seq_val = seq_val + 16'd1;
        end
    endtask

    task automatic async_reset();
        bus_if.in_valid  = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        clr              = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_edge(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_ovf   = 0;
        seq_val = 16'h0100;
        rst_n   = 1'b0;
        clr     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 16'd0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Four samples pack into one full word, popped on the following edge.
        step(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);
        check("word1_data", bus_if.out_data, 64'h0004_0003_0002_0001);
        check("word1_keep", 64'(bus_if.out_keep), 64'hF);
        check("word1_count", 64'(word_count), 64'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        check("word1_popped", 64'(word_count), 64'd0);

        // Two samples then flush alone; a second lone flush adds nothing.
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check("flush_data", bus_if.out_data, 64'h0000_0000_BBBB_AAAA);
        check("flush_keep", 64'(bus_if.out_keep), 64'h3);
        check("flush_last", 64'(bus_if.out_last), 64'd1);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check("flush_noop", 64'(word_count), 64'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Sample with flush at lane 0, then lone flush at lane 0.
        step(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
        check("vf_keep", 64'(bus_if.out_keep), 64'h1);
        check("vf_data", bus_if.out_data, 64'h1111);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check("vf_noop", 64'(word_count), 64'd1);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Overflow: DEPTH+1 words with no consumer, then drain.
        samples(4 * DEPTH, 1'b0);
        check("ovf_full", 64'(full), 64'd1);
        samples(4, 1'b0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(word_count), 64'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 64'(overflow), 64'd0);

        // Full with simultaneous push and pop, then drain across the wrap.
        samples(4 * DEPTH + 3, 1'b0);
        step(1'b1, seq_val, 1'b0, 1'b1, 1'b0);
        seq_val = seq_val + 16'd1;
        check("pp_count", 64'(word_count), 64'(DEPTH));
        check("pp_ovf", 64'(overflow), 64'd0);
        samples(8, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Clear mid-word with words queued, clr beating a concurrent sample/flush/pop.
        samples(14, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1);
        check("clr_count", 64'(word_count), 64'd0);
        check("clr_valid", 64'(bus_if.out_valid), 64'd0);
        step(1'b1, 16'h7777, 1'b1, 1'b0, 1'b0);
        check("clr_lane0", bus_if.out_data, 64'h7777);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word.
        samples(14, 1'b0);
        async_reset();
        check("rst_count", 64'(word_count), 64'd0);
        step(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        check("rst_lane0", bus_if.out_data, 64'h5A5A);
        check("rst_keep", 64'(bus_if.out_keep), 64'h1);

        // Randomized traffic: a backpressured phase then a mostly-flowing phase.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 299) == 0);
        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
